// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NPROC processors.
// Optional per-owner burst limit: define MEM_ARB_BURST_LIMIT_EN.
module mem_arbiter #(
  parameter int unsigned NPROC     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [NPROC-1:0]          i_req_rd,
  input  logic [NPROC-1:0]          i_req_wr,
  input  logic [NPROC*ADDR_W-1:0]   i_addr,
  input  logic [NPROC*3-1:0]        i_wr_size,
  input  logic [NPROC*DATA_W-1:0]   i_wdata,
  output logic [NPROC-1:0]          o_grant_rd,
  output logic [NPROC-1:0]          o_grant_wr,
  output logic [NPROC-1:0]          o_valid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [2:0]                o_mem_wr_size,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  input  logic                      i_mem_valid
);

  localparam int unsigned PTR_W = (NPROC > 1) ? $clog2(NPROC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] owner_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [PTR_W-1:0] owner_inc;
  logic [PTR_W-1:0] pick;
  logic             pick_vld;
  int unsigned      scan_idx;
  logic [NPROC-1:0] req;
  logic             owner_req;
  logic             owner_wr;
  logic             burst_hit;

  assign req       = i_req_rd | i_req_wr;
  assign owner_req = req[owner];
  assign owner_wr  = i_req_wr[owner] & ~i_req_rd[owner];
  assign owner_inc = (owner == PTR_W'(NPROC - 1)) ? '0 : owner + PTR_W'(1);

  // First requester at or after rr_ptr, wrapping modulo NPROC.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NPROC; i++) begin
      scan_idx = (32'(rr_ptr) + i) % NPROC;
      if (!pick_vld && req[PTR_W'(scan_idx)]) begin
        pick_vld = 1'b1;
        pick     = PTR_W'(scan_idx);
      end
    end
  end

`ifdef MEM_ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;

  // Counts completed OWN cycles; the BURST_MAX-th cycle releases ownership.
  assign burst_hit = (burst_cnt == CNT_W'(BURST_MAX - 1));

  always_comb begin
    burst_cnt_nxt = burst_cnt;
    if (state == IDLE && pick_vld) begin
      burst_cnt_nxt = '0;
    end else if (state == OWN && !burst_hit) begin
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      burst_cnt <= '0;
    end else begin
      burst_cnt <= burst_cnt_nxt;
    end
  end
`else
  logic unused_burst_max;

  assign burst_hit        = 1'b0;
  assign unused_burst_max = (BURST_MAX == 0);
`endif

  // State, owner and round-robin pointer registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, hold while the owner requests, one TURN gap.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (!owner_req || burst_hit) begin
          rr_ptr_nxt = owner_inc;
          state_nxt  = TURN;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs: grants and memory mux driven only while a processor owns the port.
  always_comb begin
    o_grant_rd    = '0;
    o_grant_wr    = '0;
    o_valid       = '0;
    o_mem_en      = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = '0;
    o_mem_wr_size = '0;
    o_mem_wdata   = '0;
    if (state == OWN) begin
      o_grant_rd[owner] = i_req_rd[owner];
      o_grant_wr[owner] = owner_wr;
      o_valid[owner]    = i_mem_valid;
      o_mem_en          = owner_req;
      o_mem_we          = owner_wr;
      o_mem_addr        = i_addr[32'(owner)*ADDR_W +: ADDR_W];
      o_mem_wr_size     = i_wr_size[32'(owner)*3 +: 3];
      o_mem_wdata       = i_wdata[32'(owner)*DATA_W +: DATA_W];
    end
  end

  assign o_rdata = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (NPROC=4, default widths).
module tb_mem_arbiter;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_rd;
  logic [3:0]    req_wr;
  logic [127:0]  addr;
  logic [11:0]   wr_size;
  logic [511:0]  wdata;
  logic [3:0]    grant_rd;
  logic [3:0]    grant_wr;
  logic [3:0]    valid;
  logic [127:0]  rdata;
  logic          mem_en;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [2:0]    mem_wr_size;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_valid;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .i_clk         (clk),
    .i_rstn        (rst_n),
    .i_req_rd      (req_rd),
    .i_req_wr      (req_wr),
    .i_addr        (addr),
    .i_wr_size     (wr_size),
    .i_wdata       (wdata),
    .o_grant_rd    (grant_rd),
    .o_grant_wr    (grant_wr),
    .o_valid       (valid),
    .o_rdata       (rdata),
    .o_mem_en      (mem_en),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wr_size (mem_wr_size),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .i_mem_valid   (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grants(input string tag, input logic [3:0] exp_rd, input logic [3:0] exp_wr);
    chk({tag, "_rd"}, 128'(grant_rd), 128'(exp_rd));
    chk({tag, "_wr"}, 128'(grant_wr), 128'(exp_wr));
    chk({tag, "_en"}, 128'(mem_en), 128'(|(exp_rd | exp_wr)));
    chk({tag, "_onehot"}, 128'($onehot0(grant_rd | grant_wr)), 128'd1);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] own;
    logic [3:0] exp_g;

    rst_n     = 1'b0;
    req_rd    = '0;
    req_wr    = '0;
    addr      = '0;
    wr_size   = '0;
    wdata     = '0;
    mem_rdata = '0;
    mem_valid = 1'b0;

    // Reset state
    nxt();
    #1;
    chk_grants("rst", 4'b0000, 4'b0000);
    chk("rst_we", 128'(mem_we), 128'd0);
    chk("rst_addr", 128'(mem_addr), 128'd0);
    chk("rst_valid", 128'(valid), 128'd0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      #1;
      chk_grants("idle", 4'b0000, 4'b0000);
    end

    // Single read by processor 2
    nxt();
    req_rd = 4'b0100;
    addr[2*32 +: 32] = 32'd200;
    #1;
    chk_grants("p2_lat", 4'b0000, 4'b0000);
    nxt();
    mem_valid = 1'b1;
    mem_rdata = 128'hABCD_0123;
    #1;
    chk_grants("p2_own", 4'b0100, 4'b0000);
    chk("p2_we", 128'(mem_we), 128'd0);
    chk("p2_addr", 128'(mem_addr), 128'd200);
    chk("p2_valid", 128'(valid), 128'(4'b0100));
    chk("p2_rdata", rdata, 128'hABCD_0123);
    nxt();
    req_rd = 4'b0000;
    mem_valid = 1'b0;
    #1;
    chk_grants("p2_drop", 4'b0000, 4'b0000);
    chk("p2_valid_off", 128'(valid), 128'd0);
    nxt();
    #1;
    chk_grants("p2_turn", 4'b0000, 4'b0000);

    // Processor 1: two reads then a write in one ownership
    nxt();
    req_rd = 4'b0010;
    addr[1*32 +: 32] = 32'h1000;
    #1;
    chk_grants("p1_lat", 4'b0000, 4'b0000);
    nxt();
    #1;
    chk_grants("p1_rd0", 4'b0010, 4'b0000);
    chk("p1_addr", 128'(mem_addr), 128'h1000);
    nxt();
    #1;
    chk_grants("p1_rd1", 4'b0010, 4'b0000);
    nxt();
    req_rd = 4'b0000;
    req_wr = 4'b0010;
    wr_size[1*3 +: 3] = 3'd4;
    wdata[1*128 +: 128] = 128'h2398439;
    #1;
    chk_grants("p1_wr", 4'b0000, 4'b0010);
    chk("p1_we", 128'(mem_we), 128'd1);
    chk("p1_size", 128'(mem_wr_size), 128'd4);
    chk("p1_wdata", mem_wdata, 128'h2398439);
    nxt();
    req_wr = 4'b0000;
    #1;
    chk_grants("p1_drop", 4'b0000, 4'b0000);
    nxt();
    #1;
    chk_grants("p1_turn", 4'b0000, 4'b0000);

    // Re-reset so the round-robin pointer restarts at 0
    nxt();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;

    // All four request; each drops for one cycle after two grants
    nxt();
    req_rd = 4'hF;
    #1;
    chk_grants("rr_start", 4'b0000, 4'b0000);
    for (int c = 0; c < 24; c++) begin
      nxt();
      own = 2'((c / 5) % 4);
      req_rd = 4'hF;
      if (c % 5 == 2) req_rd[own] = 1'b0;
      #1;
      exp_g = (c % 5 < 2) ? (4'b0001 << own) : 4'b0000;
      chk_grants($sformatf("rr_c%0d", c), exp_g, 4'b0000);
    end
    nxt();
    req_rd = 4'h0;
    #1;
    chk_grants("rr_end", 4'b0000, 4'b0000);

    // Owner 3 with read and write both raised; wr_size passes through
    nxt();
    req_rd = 4'b1000;
    req_wr = 4'b1000;
    addr[3*32 +: 32] = 32'h300;
    wr_size[3*3 +: 3] = 3'd7;
    #1;
    chk_grants("p3_lat", 4'b0000, 4'b0000);
    nxt();
    #1;
    chk_grants("p3_both", 4'b1000, 4'b0000);
    chk("p3_we", 128'(mem_we), 128'd0);
    chk("p3_addr", 128'(mem_addr), 128'h300);
    chk("p3_size", 128'(mem_wr_size), 128'd7);
    nxt();
    req_rd = 4'b0000;
    req_wr = 4'b0000;
    #1;
    chk_grants("p3_drop", 4'b0000, 4'b0000);
    nxt();
    req_rd = 4'b0011;
    #1;
    chk_grants("p3_turn", 4'b0000, 4'b0000);
    nxt();
    #1;
    chk_grants("wrap_idle", 4'b0000, 4'b0000);

    // Processors 0 and 1 request permanently
    for (int i = 0; i < 20; i++) begin
      nxt();
      #1;
`ifdef MEM_ARB_BURST_LIMIT_EN
      if (i < 8)       exp_g = 4'b0001;
      else if (i < 10) exp_g = 4'b0000;
      else if (i < 18) exp_g = 4'b0010;
      else             exp_g = 4'b0000;
`else
      exp_g = 4'b0001;
`endif
      chk_grants($sformatf("hold_%0d", i), exp_g, 4'b0000);
    end

    // Asynchronous reset while processor 0 owns the port
    nxt();
    #1;
    chk_grants("pre_rst", 4'b0001, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk_grants("async_rst", 4'b0000, 4'b0000);
    chk("async_rst_addr", 128'(mem_addr), 128'd0);
    nxt();
    req_rd = 4'b0000;
    rst_n = 1'b1;
    #1;
    chk_grants("post_rst", 4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between NPROC SIMD processors.
- Each processor raises separate read and write requests. The arbiter grants exactly one processor at a time, in round-robin order.
- The granted processor's address, write size and write data are muxed to the memory. Memory read data and valid are returned only to the granted processor.
- Sits between the processor array and the shared data memory.

Parameters:
- NPROC, 4, number of requesting processors (2..8)
- ADDR_W, 32, address width
- DATA_W, 128, data block width (4 lanes x 32 bits)
- BURST_MAX, 8, maximum consecutive grant cycles per owner (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_req_rd  in  NPROC  per-processor read request
- i_req_wr  in  NPROC  per-processor write request
- i_addr  in  NPROC*ADDR_W  per-processor address, processor k at bits [k*ADDR_W +: ADDR_W]
- i_wr_size  in  NPROC*3  per-processor write size in words, 1..4
- i_wdata  in  NPROC*DATA_W  per-processor write data
- o_grant_rd  out  NPROC  one-hot-or-zero read grant
- o_grant_wr  out  NPROC  one-hot-or-zero write grant
- o_valid  out  NPROC  read-data valid, routed to the owner
- o_rdata  out  DATA_W  memory read data, broadcast to all processors
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wr_size  out  3  memory write size
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_rdata  in  DATA_W  memory read data
- i_mem_valid  in  1  memory read data valid

Behaviour:
- Reset: state=IDLE, owner=0, rr_ptr=0. All grants, o_valid, o_mem_en and o_mem_we are 0. o_mem_addr, o_mem_wr_size and o_mem_wdata are 0.
- Request vector req[k] = i_req_rd[k] | i_req_wr[k].
- FSM states: IDLE, OWN, TURN.
- IDLE:
  - If any req is set, pick the first k with req[k]=1, scanning from rr_ptr upward modulo NPROC.
  - Register owner=k and move to OWN.
  - The grant appears on the cycle after the request is sampled (latency 1).
- OWN:
  - o_grant_rd[owner] = i_req_rd[owner].
  - o_grant_wr[owner] = i_req_wr[owner] & ~i_req_rd[owner]. Read has priority when both are asserted.
  - Grants are combinational from the registered owner and the live requests.
  - o_mem_en = req[owner]; o_mem_we = o_grant_wr[owner].
  - o_mem_addr, o_mem_wr_size and o_mem_wdata come from the owner's slice.
  - Ownership is held while req[owner] stays 1. This lets a processor do back-to-back fetches and a writeback without re-arbitration.
  - When req[owner] drops to 0: rr_ptr = (owner+1) mod NPROC, then go to TURN.
- TURN:
  - One idle cycle with all grants 0 and o_mem_en=0.
  - Next state is IDLE, which re-arbitrates on the following cycle.
- o_valid[k] = i_mem_valid & (state==OWN) & (k==owner); all other bits are 0.
- o_rdata = i_mem_rdata, unregistered.
- i_wr_size value 0 or greater than 4 is passed through unchanged; memory clamps it.
- New requests during OWN or TURN from non-owners wait; no request is dropped.
- Wrap-around: with owner = NPROC-1, rr_ptr becomes 0.
- An owner that drops and immediately re-raises its request still passes through TURN. It is then the lowest priority in the next scan.
- Reset mid-operation: grants and o_mem_en clear immediately (asynchronous). A partially completed memory write is not retried.
- Exactly one bit of o_grant_rd | o_grant_wr is set at any time, or none. The bench checks this as an invariant.

Optional Feature:
- Macro: MEM_ARB_BURST_LIMIT_EN.
- Defined:
  - A counter (width clog2(BURST_MAX+1)) counts OWN cycles.
  - When it reaches BURST_MAX while req[owner] is still 1, ownership is forcibly released. rr_ptr = owner+1, go to TURN; the counter clears on entering OWN.
  - The preempted processor keeps its request and is re-granted in a later round.
- Not defined: no counter; ownership is unbounded while req[owner] stays 1.

Test Plan:
- Reset, no requests for 5 cycles -> all grants 0, o_mem_en=0, state IDLE.
- i_req_rd=4'b0100 with i_addr[2]=200 -> o_grant_rd=4'b0100 one cycle later. o_mem_addr=200, o_mem_we=0. i_mem_valid=1 gives o_valid=4'b0100.
- Processor 1 holds i_req_rd for 2 cycles, then i_req_wr with wr_size=4 and wdata=0x...2398439 for 1 cycle -> a single continuous ownership. o_mem_we=1 on the write cycle, o_mem_wr_size=4.
- All four request continuously, each dropping after 2 granted cycles -> grant order 0,1,2,3,0, with one TURN cycle between owners.
- i_req_rd and i_req_wr both set on owner 3 -> o_grant_rd=4'b1000, o_grant_wr=0. On release, next rr_ptr=0.
- With MEM_ARB_BURST_LIMIT_EN and BURST_MAX=8, processors 0 and 1 request permanently -> processor 0 is granted 8 cycles, 1 TURN cycle, then processor 1 for 8 cycles. Without the macro, processor 0 holds indefinitely.
